quad_decoder_array: RTL and testbench

//  Multi-channel quadrature decoder. Successor to the single-channel encoder counter.
//  Per channel: input synchroniser, glitch filter, 4x decode, wrapping position count,

---
 rtl/quad_decoder_array.sv | 142 ++++++++++++++
 tb/tb_quad_decoder_array.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder_array.sv
// rtl/quad_decoder_array.sv - multi-channel quadrature decoder: sync, glitch filter, 4x decode, index zeroing, error flag, windowed velocity
// Count updates a fixed 2+FILT_LEN clocks after a raw pin change is first sampled.
module quad_decoder_array #(
   parameter int NUM_CH        = 4,
   parameter int COUNT_W       = 32,
   parameter int VEL_W         = 16,
   parameter int FILT_LEN      = 3,
   parameter int WINDOW_CYCLES = 1200000
) (
   input  logic                      clk_12MHz,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         a,
   input  logic [NUM_CH-1:0]         b,
   input  logic [NUM_CH-1:0]         idx,
   input  logic [NUM_CH-1:0]         clear,
   input  logic [NUM_CH-1:0]         idx_zero_en,
   input  logic [NUM_CH-1:0]         err_clr,
   output logic [NUM_CH*COUNT_W-1:0] count,
   output logic [NUM_CH*VEL_W-1:0]   velocity,
   output logic                      vel_valid,
   output logic [NUM_CH-1:0]         err
);
   localparam int NS   = 3 * NUM_CH;
   localparam int FC_W = $clog2(FILT_LEN + 1);
   localparam int WW   = $clog2(WINDOW_CYCLES);
   localparam logic [FC_W-1:0]         FILT_TOP = FC_W'(FILT_LEN - 1);
   localparam logic [WW-1:0]           WIN_TOP  = WW'(WINDOW_CYCLES - 1);
   localparam logic signed [VEL_W-1:0] VEL_MAX  = {1'b0, {(VEL_W-1){1'b1}}};
   localparam logic signed [VEL_W-1:0] VEL_MIN  = {1'b1, {(VEL_W-1){1'b0}}};

   logic [NS-1:0]     raw, sync1, sync2, filt;
   logic [FC_W-1:0]   fcnt [NS];
   logic [NUM_CH-1:0] filt_a, filt_b, filt_i;
   logic [NUM_CH-1:0] prev_a, prev_b, prev_i;
   logic [NUM_CH-1:0] step_up, step_dn, illegal, idx_rise;
   logic [WW-1:0]     win_cnt;
   logic              win_end;

   logic [COUNT_W-1:0]        cnt_r    [NUM_CH];
   logic signed [VEL_W-1:0]   acc      [NUM_CH];
   logic signed [VEL_W-1:0]   acc_next [NUM_CH];
   logic signed [VEL_W-1:0]   vel_r    [NUM_CH];

   // Position of an {A,B} state around the Gray cycle 00->01->11->10.
   function automatic logic [1:0] gray_pos(input logic [1:0] ab);
      case (ab)
         2'b00:   return 2'd0;
         2'b01:   return 2'd1;
         2'b11:   return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   assign raw    = {idx, b, a};
   assign filt_a = filt[NUM_CH-1:0];
   assign filt_b = filt[2*NUM_CH-1:NUM_CH];
   assign filt_i = filt[NS-1:2*NUM_CH];

   always_ff @(posedge clk_12MHz) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         filt  <= '0;
         for (int s = 0; s < NS; s++) fcnt[s] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int s = 0; s < NS; s++) begin
            if (sync2[s] == filt[s]) begin
               fcnt[s] <= '0;
            end else if (fcnt[s] == FILT_TOP) begin
               filt[s] <= sync2[s];
               fcnt[s] <= '0;
            end else begin
               fcnt[s] <= fcnt[s] + FC_W'(1);
            end
         end
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic [1:0] pos_diff;
      assign pos_diff      = gray_pos({filt_a[ch], filt_b[ch]}) - gray_pos({prev_a[ch], prev_b[ch]});
      assign step_up[ch]   = (pos_diff == 2'd1);
      assign step_dn[ch]   = (pos_diff == 2'd3);
      assign illegal[ch]   = (pos_diff == 2'd2);
      assign idx_rise[ch]  = filt_i[ch] & ~prev_i[ch];
      // Velocity saturates; the position count wraps freely.
      assign acc_next[ch]  = (step_up[ch] && acc[ch] != VEL_MAX) ? acc[ch] + VEL_W'(1) :
                             (step_dn[ch] && acc[ch] != VEL_MIN) ? acc[ch] - VEL_W'(1) :
                             acc[ch];
      assign count[ch*COUNT_W +: COUNT_W] = cnt_r[ch];
      assign velocity[ch*VEL_W +: VEL_W]  = vel_r[ch];
   end

   assign win_end = (win_cnt == WIN_TOP);

   always_ff @(posedge clk_12MHz) begin
      if (reset) begin
         win_cnt   <= '0;
         vel_valid <= 1'b0;
         prev_a    <= '0;
         prev_b    <= '0;
         prev_i    <= '0;
         err       <= '0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            cnt_r[ch] <= '0;
            acc[ch]   <= '0;
            vel_r[ch] <= '0;
         end
      end else begin
         prev_a    <= filt_a;
         prev_b    <= filt_b;
         prev_i    <= filt_i;
         vel_valid <= win_end;
         win_cnt   <= win_end ? '0 : win_cnt + WW'(1);
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (clear[ch])
               cnt_r[ch] <= '0;
            else if (idx_zero_en[ch] && idx_rise[ch])
               cnt_r[ch] <= '0;
            else if (step_up[ch])
               cnt_r[ch] <= cnt_r[ch] + COUNT_W'(1);
            else if (step_dn[ch])
               cnt_r[ch] <= cnt_r[ch] - COUNT_W'(1);

            // A new illegal transition outranks a same-cycle clear request.
            if (illegal[ch])
               err[ch] <= 1'b1;
            else if (err_clr[ch])
               err[ch] <= 1'b0;

            if (win_end) begin
               vel_r[ch] <= acc_next[ch];
               acc[ch]   <= '0;
            end else begin
               acc[ch]   <= acc_next[ch];
            end
         end
      end
   end
endmodule

// File: tb/tb_quad_decoder_array.sv
// tb/tb_quad_decoder_array.sv - directed bench for quad_decoder_array across three parameter sets
module tb_quad_decoder_array;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // u_f: FILT_LEN=3, 4 channels, default window
   logic         rst_f;
   logic [3:0]   a_f, b_f, idx_f, clr_f, ize_f, ecl_f;
   logic [127:0] count_f;
   logic [63:0]  vel_f;
   logic         vv_f;
   logic [3:0]   err_f;

   // u_w: FILT_LEN=1, window 100
   logic         rst_w;
   logic [1:0]   a_w, b_w, idx_w, clr_w, ize_w, ecl_w;
   logic [63:0]  count_w;
   logic [31:0]  vel_w;
   logic         vv_w;
   logic [1:0]   err_w;

   // u_s: FILT_LEN=1, VEL_W=8, window 400
   logic         rst_s;
   logic [0:0]   a_s, b_s, idx_s, clr_s, ize_s, ecl_s;
   logic [15:0]  count_s;
   logic [7:0]   vel_s;
   logic         vv_s;
   logic [0:0]   err_s;

   quad_decoder_array #(.NUM_CH(4), .COUNT_W(32), .VEL_W(16), .FILT_LEN(3), .WINDOW_CYCLES(1200000)) u_f (
      .clk_12MHz(clk), .reset(rst_f), .a(a_f), .b(b_f), .idx(idx_f), .clear(clr_f),
      .idx_zero_en(ize_f), .err_clr(ecl_f), .count(count_f), .velocity(vel_f),
      .vel_valid(vv_f), .err(err_f));

   quad_decoder_array #(.NUM_CH(2), .COUNT_W(32), .VEL_W(16), .FILT_LEN(1), .WINDOW_CYCLES(100)) u_w (
      .clk_12MHz(clk), .reset(rst_w), .a(a_w), .b(b_w), .idx(idx_w), .clear(clr_w),
      .idx_zero_en(ize_w), .err_clr(ecl_w), .count(count_w), .velocity(vel_w),
      .vel_valid(vv_w), .err(err_w));

   quad_decoder_array #(.NUM_CH(1), .COUNT_W(16), .VEL_W(8), .FILT_LEN(1), .WINDOW_CYCLES(400)) u_s (
      .clk_12MHz(clk), .reset(rst_s), .a(a_s), .b(b_s), .idx(idx_s), .clear(clr_s),
      .idx_zero_en(ize_s), .err_clr(ecl_s), .count(count_s), .velocity(vel_s),
      .vel_valid(vv_s), .err(err_s));

   int pos_f [4];
   int pos_w;
   int pos_s;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] gray(input int p);
      case (p & 3)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   task automatic f_set(input int ch, input int dir);
      logic [1:0] g;
      pos_f[ch] = (pos_f[ch] + dir) & 3;
      g = gray(pos_f[ch]);
      a_f[ch] = g[1];
      b_f[ch] = g[0];
   endtask

   task automatic f_steps(input int ch, input int dir, input int n);
      for (int i = 0; i < n; i++) begin
         f_set(ch, dir);
         tick(7);
      end
   endtask

   task automatic w_steps(input int n);
      logic [1:0] g;
      for (int i = 0; i < n; i++) begin
         pos_w = (pos_w + 1) & 3;
         g = gray(pos_w);
         a_w[0] = g[1];
         b_w[0] = g[0];
         tick(1);
      end
   endtask

   task automatic s_steps(input int dir, input int n);
      logic [1:0] g;
      for (int i = 0; i < n; i++) begin
         pos_s = (pos_s + dir) & 3;
         g = gray(pos_s);
         a_s[0] = g[1];
         b_s[0] = g[0];
         tick(1);
      end
   endtask

   initial begin
      rst_f = 1'b1; rst_w = 1'b1; rst_s = 1'b1;
      a_f = '0; b_f = '0; idx_f = '0; clr_f = '0; ize_f = '0; ecl_f = '0;
      a_w = '0; b_w = '0; idx_w = '0; clr_w = '0; ize_w = '0; ecl_w = '0;
      a_s = '0; b_s = '0; idx_s = '0; clr_s = '0; ize_s = '0; ecl_s = '0;
      for (int i = 0; i < 4; i++) pos_f[i] = 0;
      pos_w = 0;
      pos_s = 0;
      tick(3);

      chk("reset_count", count_f, 128'h0);
      chk("reset_vel", vel_f, 64'h0);
      chk("reset_vv", vv_f, 1'b0);
      chk("reset_err", err_f, 4'h0);
      rst_f = 1'b0;
      tick(2);

      // One CW step on ch0: count moves on the 6th edge after the change is set
      f_set(0, 1);
      tick(5);
      chk("cw_latency_before", count_f[31:0], 32'd0);
      tick(1);
      chk("cw_latency_at", count_f[31:0], 32'd1);
      chk("cw_others_zero", count_f[127:32], 96'h0);
      tick(1);

      // 2-cycle glitch on ch1 A is rejected, then 4 CCW steps
      a_f[1] = 1'b1;
      tick(2);
      a_f[1] = 1'b0;
      tick(8);
      chk("glitch_ignored", count_f[63:32], 32'd0);
      f_steps(1, -1, 4);
      chk("ccw_underflow", count_f[63:32], 32'hFFFF_FFFC);
      chk("ccw_err", err_f, 4'h0);
      f_steps(1, 1, 4);
      chk("cw_wrap_to_zero", count_f[63:32], 32'd0);

      // Illegal AB 00->11 on ch2
      a_f[2] = 1'b1; b_f[2] = 1'b1;
      tick(7);
      chk("illegal_count", count_f[95:64], 32'd0);
      chk("illegal_err", err_f, 4'b0100);
      ecl_f[2] = 1'b1;
      tick(1);
      ecl_f[2] = 1'b0;
      chk("err_clr", err_f, 4'b0000);
      a_f[2] = 1'b0; b_f[2] = 1'b0;
      tick(5);
      ecl_f[2] = 1'b1;
      tick(1);
      ecl_f[2] = 1'b0;
      chk("err_set_beats_clr", err_f, 4'b0100);
      tick(2);

      // Index rising with a coincident CW step at count 42
      f_steps(3, 1, 42);
      f_steps(0, 1, 41);
      chk("pre_idx_ch3", count_f[127:96], 32'd42);
      chk("pre_idx_ch0", count_f[31:0], 32'd42);
      ize_f = 4'b1000;
      idx_f[0] = 1'b1; idx_f[3] = 1'b1;
      f_set(0, 1);
      f_set(3, 1);
      tick(7);
      chk("idx_zero_en1", count_f[127:96], 32'd0);
      chk("idx_zero_en0", count_f[31:0], 32'd43);

      // Reset mid-run clears every output on the next cycle
      rst_f = 1'b1;
      tick(1);
      chk("midrun_rst_count", count_f, 128'h0);
      chk("midrun_rst_err", err_f, 4'h0);
      chk("midrun_rst_vel", vel_f, 64'h0);
      chk("midrun_rst_vv", vv_f, 1'b0);

      // Window of 100: 20 steps, clear, 17 steps
      rst_w = 1'b0;
      tick(9);
      w_steps(20);
      tick(5);
      clr_w[0] = 1'b1;
      tick(2);
      clr_w[0] = 1'b0;
      w_steps(17);
      tick(46);
      chk("win_vv_before", vv_w, 1'b0);
      chk("win_vel_before", vel_w, 32'h0);
      tick(1);
      chk("win_vv_at_100", vv_w, 1'b1);
      chk("win_vel", vel_w, {16'd0, 16'd37});
      chk("win_count_clear", count_w, {32'd0, 32'd17});
      tick(1);
      chk("win_vv_one_cycle", vv_w, 1'b0);
      chk("win_vel_held", vel_w[15:0], 16'd37);
      tick(98);
      chk("win_vv_before_200", vv_w, 1'b0);
      tick(1);
      chk("win_vv_at_200", vv_w, 1'b1);
      chk("win_vel_empty", vel_w, 32'h0);

      // VEL_W=8 saturation in both directions
      rst_s = 1'b0;
      tick(9);
      s_steps(1, 300);
      tick(91);
      chk("sat_vv", vv_s, 1'b1);
      chk("sat_pos", vel_s, 8'h7F);
      chk("sat_count", count_s, 16'd300);
      tick(399);
      chk("sat_vv_gap", vv_s, 1'b0);
      tick(1);
      chk("sat_empty_window", vel_s, 8'h00);
      s_steps(-1, 300);
      tick(100);
      chk("sat_neg", vel_s, 8'h80);
      chk("sat_count_back", count_s, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
